// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - RV32I instruction encoder feeding a write FIFO into instruction memory.
// Optional immediate range checking: define RV32_INSTR_ENCODER_RANGE_CHECK_EN.
module rv32_instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_kind_i,
  input  logic [2:0]            req_funct3_i,
  input  logic                  req_funct7b5_i,
  input  logic [4:0]            req_rd_i,
  input  logic [4:0]            req_rs1_i,
  input  logic [4:0]            req_rs2_i,
  input  logic [31:0]           req_imm_i,
  output logic                  imem_we_o,
  input  logic                  imem_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [PW:0] DEPTH_OCC = (PW+1)'(FIFO_DEPTH);

  localparam logic [2:0] K_LW   = 3'd0;
  localparam logic [2:0] K_SW   = 3'd1;
  localparam logic [2:0] K_R    = 3'd2;
  localparam logic [2:0] K_BEQ  = 3'd3;
  localparam logic [2:0] K_IALU = 3'd4;
  localparam logic [2:0] K_JAL  = 3'd5;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic          fifo_full, fifo_empty;

  logic [31:0] enc_word;
  logic        kind_legal;
  logic        imm_ok;
  logic        is_shift;
  logic        accept, push, pop, err_set;

  assign is_shift = (req_funct3_i == 3'b001) || (req_funct3_i == 3'b101);

  always_comb begin
    enc_word   = '0;
    kind_legal = 1'b1;
    case (req_kind_i)
      K_LW:   enc_word = {req_imm_i[11:0], req_rs1_i, 3'b010, req_rd_i, 7'b0000011};
      K_SW:   enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010,
                          req_imm_i[4:0], 7'b0100011};
      K_R:    enc_word = {1'b0, req_funct7b5_i, 5'b00000, req_rs2_i, req_rs1_i,
                          req_funct3_i, req_rd_i, 7'b0110011};
      K_BEQ:  enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, 3'b000,
                          req_imm_i[4:1], req_imm_i[11], 7'b1100011};
      K_IALU: begin
        if (is_shift)
          enc_word = {1'b0, req_funct7b5_i, 5'b00000, req_imm_i[4:0], req_rs1_i,
                      req_funct3_i, req_rd_i, 7'b0010011};
        else
          enc_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, 7'b0010011};
      end
      K_JAL:  enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                          req_rd_i, 7'b1101111};
      default: kind_legal = 1'b0;
    endcase
  end

`ifdef RV32_INSTR_ENCODER_RANGE_CHECK_EN
  // A field fits when every bit above its sign bit matches the sign bit.
  logic fits12, fits13, fits21;
  assign fits12 = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
  assign fits13 = (&req_imm_i[31:12]) | ~(|req_imm_i[31:12]);
  assign fits21 = (&req_imm_i[31:20]) | ~(|req_imm_i[31:20]);

  always_comb begin
    imm_ok = 1'b1;
    case (req_kind_i)
      K_LW, K_SW: imm_ok = fits12;
      K_BEQ:      imm_ok = fits13 & ~req_imm_i[0];
      K_IALU:     imm_ok = is_shift ? ~(|req_imm_i[31:5]) : fits12;
      K_JAL:      imm_ok = fits21 & ~req_imm_i[0];
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm_bits;
  assign unused_imm_bits = ^req_imm_i[31:21];
  assign imm_ok = 1'b1;
`endif

  assign fifo_full   = (occ == DEPTH_OCC);
  assign fifo_empty  = (occ == '0);
  assign req_ready_o = ~fifo_full;
  assign imem_we_o   = ~fifo_empty;
  assign imem_wdata_o = fifo_empty ? 32'd0 : mem[rd_ptr];

  // Flush overrides any same-cycle accept or transfer.
  assign accept  = req_valid_i & req_ready_o;
  assign push    = accept & kind_legal & imm_ok & ~flush_i;
  assign pop     = imem_we_o & imem_ready_i & ~flush_i;
  assign err_set = accept & ~(kind_legal & imm_ok) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      imem_addr_o <= BASE;
      count_o     <= '0;
      err_o       <= 1'b0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      imem_addr_o <= BASE;
      count_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        imem_addr_o <= imem_addr_o + 1'b1;
        if (count_o != '1)
          count_o <= count_o + 1'b1;
      end
      if (push && !pop)
        occ <= occ + 1'b1;
      else if (pop && !push)
        occ <= occ - 1'b1;
      if (err_set)
        err_o <= 1'b1;
    end
  end

endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Streaming RV32I instruction encoder and program loader: the encoding counterpart to the control-path main decoder. It accepts instruction descriptions (kind, register fields, immediate) over a valid/ready handshake and packs them into 32-bit RV32I words. It buffers the words in a small FIFO and writes them to sequential word addresses of instruction memory. Used by test infrastructure and the boot loader to fill instruction memory before the core runs.

## Interface
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)
- ADDR_WIDTH, 10, instruction-memory word-address width
- BASE_ADDR, 0, first write address after reset/flush
- clk_i  in  1  clock; all logic rising-edge
- rst_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous clear of FIFO, address counter, error flag
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_kind_i  in  3  0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU, 5 jal, 6–7 illegal
- req_funct3_i  in  3  funct3 for R-type / I-type ALU (ignored otherwise)
- req_funct7b5_i  in  1  instr[30] for R-type and I-type shifts
- req_rd_i, req_rs1_i, req_rs2_i  in  5 each  register indices
- req_imm_i  in  32  signed byte offset / immediate
- imem_we_o  out  1  write request (FIFO non-empty)
- imem_ready_i  in  1  memory accepts write this cycle
- imem_addr_o  out  ADDR_WIDTH  word address of current write
- imem_wdata_o  out  32  encoded instruction word
- count_o  out  ADDR_WIDTH+1  words written since reset/flush (saturating)
- err_o  out  1  sticky: illegal kind or range violation seen

## Operation
- Encoding (combinational from the request, registered into the FIFO on accept):
  - lw: imm[11:0], rs1, 010, rd, 0000011
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011
  - R-type: {0, funct7b5, 00000}, rs2, rs1, funct3, rd, 0110011
  - beq: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011
  - I-type ALU: imm[11:0], rs1, funct3, rd, 0010011; when funct3 is 001 or 101, bits [31:25] = {0, funct7b5, 00000} and bits [24:20] = imm[4:0]
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111
- req_ready_o = !fifo_full. An accepted illegal kind (6–7) sets err_o and is not enqueued.
- Write side: imm_we_o = !fifo_empty. The head word transfers when imem_we_o && imem_ready_i. The entry is then popped and the address increments by 1, wrapping modulo 2^ADDR_WIDTH. count_o increments and saturates at all-ones.
- imem_wdata_o = FIFO head when non-empty, else 0.
- Simultaneous push and pop: occupancy unchanged, both take effect. Push is never allowed while full, because ready is low.
- flush_i has priority over the same-cycle accept and transfer. Neither takes effect. The FIFO empties, the address returns to BASE_ADDR, and count_o and err_o clear.
- Reset (asserting rst_ni low, mid-operation included) discards all state immediately.

## Timing
- Reset values: req_ready_o=1, imem_we_o=0, imem_addr_o=BASE_ADDR, imem_wdata_o=0, count_o=0, err_o=0.
- Accept at edge N → imem_we_o=1 with the word from cycle N+1 (1-cycle latency, no bypass).
- Sustained throughput of 1 word/cycle when imem_ready_i is held high.
- err_o rises the cycle after the offending accept and holds until flush or reset.
- req_ready_o falls the cycle after the FIFO_DEPTH-th outstanding entry is written.

## Configuration
- RV32_INSTR_ENCODER_RANGE_CHECK_EN defined:
  - An accepted request is dropped (not enqueued) and sets err_o when its immediate is out of range.
  - Out of range means: not representable as the signed field (12-bit lw/sw/I-ALU, 13-bit beq, 21-bit jal); beq/jal imm[0]≠0; or a shift amount above 31.
- Undefined: immediates are silently truncated to field bits and every legal kind is enqueued.

## Test plan
- Encode each kind with imem_ready_i=1:
  - lw rd=6 rs1=9 imm=−4 → 0xFFC4A303
  - sw rs2=6 rs1=9 imm=8 → 0x0064A423
  - add rd=4 rs1=5 rs2=6 → 0x00628233
  - beq rs1=rs2=4 imm=8 → 0x00420463
  - jal rd=1 imm=8 → 0x008000EF
  - Expect addresses 0..4 and count_o=5.
- Backpressure: imem_ready_i=0, offer 5 requests → 4 accepted, req_ready_o=0. Raise ready → 4 writes at addresses 0..3 in order, then the 5th is accepted.
- Illegal kind 7 → handshake completes, err_o=1 next cycle, no write. flush_i → err_o=0, address=BASE_ADDR.
- Flush with 3 entries queued and a same-cycle accept → imem_we_o=0 next cycle, count_o=0, nothing enqueued.
- lw imm=2048: with macro → err_o=1, no write. Without macro → word 0x80002003 (rd=0, rs1=0).
- rst_ni pulsed low mid-stream, asynchronous to clk_i → all outputs at reset values within the same cycle, FIFO empty afterwards.
